alu_seq: RTL and testbench

Parametrised multi-cycle successor to the team's combinational 8-bit ALU. It registers its operands on a Start/Done handshake, then executes:
- single-cycle logic and arithmetic;
- variable-distance shifts and rotates, one bit per cycle;
- an optional iterative shift-add multiply.

Results and status flags are registered and held until the next completion. It sits between the register file read ports and the writeback mux; the controller stalls on Busy.

---
 rtl/alu_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial
//            shifts/rotates, and (with ALU_SEQ_MUL_EN) shift-add multiply.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [2:0]   OP,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic         SC_in,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Out,
    output logic [W-1:0] OutHi,
    output logic         SC_out,
    output logic         Zero,
    output logic         PF
);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_lsh = 3'b001;
    localparam logic [2:0] c_op_bsh = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_and = 3'b100;
    localparam logic [2:0] c_op_sub = 3'b101;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] c_op_mul = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic           rot_q, rot_d;
    logic           fill_q, fill_d;
    logic [W-1:0]   a_q, a_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;
    logic           sc_q, sc_d;
    logic           zero_q, pf_q;
    logic           done_q, done_d;

    logic [SW-1:0]  w_k;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_shift;
    logic [W-1:0]   w_res;
    logic           w_res_sc;
    logic           w_wr;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   outhi_q, outhi_d;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_acc_next;
    logic [W-1:0]   w_res_hi;
`endif

    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        fill_d   = fill_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        w_res    = '0;
        w_res_sc = 1'b0;
        w_wr     = 1'b0;
        w_k      = InputB[SW-1:0];
        w_sum    = {1'b0, InputA} + {1'b0, InputB};
        // The extra MSB of the difference is the unsigned borrow (A < B).
        w_diff   = {1'b0, InputA} - {1'b0, InputB};
        w_shift  = rot_q ? {a_q[W-2:0], a_q[W-1]} : {a_q[W-2:0], fill_q};
`ifdef ALU_SEQ_MUL_EN
        b_d        = b_q;
        acc_d      = acc_q;
        w_res_hi   = '0;
        w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        w_acc_next = {w_mul_sum, acc_q[W-1:1]};
`endif

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (OP)
                        c_op_add: begin
                            w_res    = w_sum[W-1:0];
                            w_res_sc = w_sum[W];
                            w_wr     = 1'b1;
                            done_d   = 1'b1;
                        end
                        c_op_sub: begin
                            w_res    = w_diff[W-1:0];
                            w_res_sc = w_diff[W];
                            w_wr     = 1'b1;
                            done_d   = 1'b1;
                        end
                        c_op_xor: begin
                            w_res  = InputA ^ InputB;
                            w_wr   = 1'b1;
                            done_d = 1'b1;
                        end
                        c_op_and: begin
                            w_res  = InputA & InputB;
                            w_wr   = 1'b1;
                            done_d = 1'b1;
                        end
                        c_op_lsh, c_op_bsh: begin
                            if (w_k == '0) begin
                                w_res  = InputA;
                                w_wr   = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d = S_SHIFT;
                                a_d     = InputA;
                                cnt_d   = w_k - SW'(1);
                                rot_d   = (OP == c_op_bsh);
                                fill_d  = SC_in;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        c_op_mul: begin
                            state_d = S_MUL;
                            a_d     = InputA;
                            b_d     = InputB;
                            acc_d   = '0;
                            cnt_d   = SW'(W - 1);
                        end
`endif
                        // NOP (and 110 without the multiplier): pulse Done, hold results.
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_SHIFT: begin
                a_d = w_shift;
                if (cnt_q == '0) begin
                    w_res    = w_shift;
                    w_res_sc = a_q[W-1];
                    w_wr     = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                acc_d = w_acc_next;
                b_d   = b_q >> 1;
                if (cnt_q == '0) begin
                    w_res    = w_acc_next[W-1:0];
                    w_res_hi = w_acc_next[2*W-1:W];
                    w_res_sc = |w_acc_next[2*W-1:W];
                    w_wr     = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        out_d = w_wr ? w_res    : out_q;
        sc_d  = w_wr ? w_res_sc : sc_q;
`ifdef ALU_SEQ_MUL_EN
        outhi_d = w_wr ? w_res_hi : outhi_q;
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
            a_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            sc_q    <= 1'b0;
            zero_q  <= 1'b1;
            pf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            fill_q  <= fill_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            sc_q    <= sc_d;
            zero_q  <= ~|out_d;
            pf_q    <= ^out_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            b_q     <= '0;
            acc_q   <= '0;
            outhi_q <= '0;
        end else begin
            b_q     <= b_d;
            acc_q   <= acc_d;
            outhi_q <= outhi_d;
        end
    end

    assign OutHi = outhi_q;
`else
    assign OutHi = '0;
`endif

    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign Out    = out_q;
    assign SC_out = sc_q;
    assign Zero   = zero_q;
    assign PF     = pf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq (W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [2:0]   OP;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         SC_in;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Out;
    logic [W-1:0] OutHi;
    logic         SC_out;
    logic         Zero;
    logic         PF;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.W(W)) u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .OP      (OP),
        .InputA  (InputA),
        .InputB  (InputB),
        .SC_in   (SC_in),
        .Busy    (Busy),
        .Done    (Done),
        .Out     (Out),
        .OutHi   (OutHi),
        .SC_out  (SC_out),
        .Zero    (Zero),
        .PF      (PF)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sc);
        Start  = 1'b1;
        OP     = op;
        InputA = a;
        InputB = b;
        SC_in  = sc;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        lat = 0;
        while (Done !== 1'b1 && lat < max_cyc) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] o, input logic [W-1:0] hi,
                              input logic sc, input logic z, input logic p);
        check_eq({tag, "_out"},  Out,    o);
        check_eq({tag, "_hi"},   OutHi,  hi);
        check_eq({tag, "_sc"},   SC_out, sc);
        check_eq({tag, "_zero"}, Zero,   z);
        check_eq({tag, "_pf"},   PF,     p);
    endtask

    int lat;
    int n_done;

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        OP      = 3'b111;
        InputA  = '0;
        InputB  = '0;
        SC_in   = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_done", Done, 1'b0);
        check_outs("rst", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // ADD 0xF0 + 0x20
        issue(3'b000, 8'hF0, 8'h20, 1'b0);
        check_eq("add_done", Done, 1'b1);
        check_eq("add_busy", Busy, 1'b0);
        check_outs("add", 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        check_eq("add_done_pulse", Done, 1'b0);
        check_eq("add_hold", Out, 8'h10);

        // SUB equal operands, then a back-to-back SUB with borrow
        issue(3'b101, 8'h05, 8'h05, 1'b0);
        check_eq("sub0_done", Done, 1'b1);
        check_outs("sub0", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        issue(3'b101, 8'h03, 8'h05, 1'b0);
        check_eq("sub1_done", Done, 1'b1);
        check_outs("sub1", 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1);

        // LSH 0x81 by 3 with fill 1; an ADD 0+0 issued mid-shift must be ignored
        issue(3'b001, 8'h81, 8'h03, 1'b1);
        check_eq("lsh_busy1", Busy, 1'b1);
        check_eq("lsh_nodone1", Done, 1'b0);
        issue(3'b000, 8'h00, 8'h00, 1'b0);
        check_eq("lsh_busy2", Busy, 1'b1);
        check_eq("lsh_nodone2", Done, 1'b0);
        wait_done(20, lat);
        check_eq("lsh_lat", lat + 1, 3);
        check_eq("lsh_busy_done", Busy, 1'b0);
        check_outs("lsh", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check_eq("lsh_done_pulse", Done, 1'b0);
        check_eq("lsh_hold", Out, 8'h0F);

        // BSH 0x81 by 1, then by 8 (k=0)
        issue(3'b010, 8'h81, 8'h01, 1'b0);
        check_eq("bsh1_busy", Busy, 1'b1);
        wait_done(20, lat);
        check_eq("bsh1_lat", lat, 1);
        check_outs("bsh1", 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        issue(3'b010, 8'h81, 8'h08, 1'b0);
        check_eq("bsh0_done", Done, 1'b1);
        check_eq("bsh0_busy", Busy, 1'b0);
        check_outs("bsh0", 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);

        // MUL 0x10 * 0x20
        issue(3'b110, 8'h10, 8'h20, 1'b0);
        wait_done(20, lat);
`ifdef ALU_SEQ_MUL_EN
        check_eq("mul_lat", lat, 8);
        check_outs("mul", 8'h00, 8'h02, 1'b1, 1'b1, 1'b0);
        @(negedge Clk);
        issue(3'b110, 8'h0D, 8'h0B, 1'b0);
        wait_done(20, lat);
        check_eq("mul2_lat", lat, 8);
        check_outs("mul2", 8'h8F, 8'h00, 1'b0, 1'b0, 1'b1);
`else
        check_eq("mul_lat", lat, 0);
        check_outs("mul_nop", 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        @(negedge Clk);

        // Reset asserted four cycles into a MUL
        n_done = 0;
        issue(3'b110, 8'h10, 8'h20, 1'b0);
        repeat (3) begin
            @(negedge Clk);
            if (Done === 1'b1) n_done++;
        end
        Reset_n = 1'b0;
        #1;
        check_eq("arst_busy", Busy, 1'b0);
        check_outs("arst", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge Clk);
            if (Done === 1'b1) n_done++;
        end
        Reset_n = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (Done === 1'b1) n_done++;
        end
        check_eq("arst_no_done", n_done, 0);
        check_eq("arst_busy_after", Busy, 1'b0);

        issue(3'b000, 8'h01, 8'h01, 1'b0);
        check_eq("post_done", Done, 1'b1);
        check_outs("post", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
